iterative_divider: RTL and testbench
====================================

Name: iterative_divider

Overview:
- Multi-cycle radix-2 restoring divider executing DIV/DIVU in the EXE stage.
- Its o_busy output drives the pipeline controller's i_div_busy input, which freezes all pipeline stage enables and the controller's own fill shift register while a division is in flight.
- Results are written to HI/LO downstream.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and at least 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  level: a DIV/DIVU instruction occupies EXE with valid operands
- i_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- i_dividend  input  WIDTH  rs operand
- i_divisor  input  WIDTH  rt operand
- i_cancel  input  1  flush from the exception path; aborts any operation
- o_busy  output  1  to the pipeline controller's i_div_busy
- o_done  output  1  one-cycle pulse: results valid and about to retire
- o_quotient  output  WIDTH  LO value
- o_remainder  output  WIDTH  HI value

Behaviour:
- States: IDLE, RUN, DONE. On reset: state=IDLE, counter=0, o_done=0, o_quotient=0, o_remainder=0, all internal registers 0. o_busy is 0 whenever reset is asserted.
- o_busy = (state==RUN) | (state==IDLE & i_start & ~i_cancel).
  - The IDLE term is combinational so the pipeline stalls in the same cycle the DIV instruction is first seen.
- IDLE, on i_start & ~i_cancel at cycle T:
  - Latch |dividend| and |divisor|; take absolute values only when i_signed.
  - Latch quotient sign (sign of dividend XOR sign of divisor, when i_signed) and remainder sign (sign of dividend, when i_signed).
  - Clear the partial remainder; counter = WIDTH-1; go to RUN.
- RUN, one restoring step per cycle, WIDTH cycles (T+1 .. T+WIDTH):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set the quotient bit to 0.
  - After the step with counter==0, go to DONE.
- DONE at cycle T+WIDTH+1:
  - o_done=1 and o_busy=0.
  - o_quotient and o_remainder are registered, with sign correction by two's-complement negation where the latched signs require it.
  - The outputs hold until the next accepted start.
  - i_start is ignored in DONE; this prevents a re-issue while the pipeline advances past the retiring instruction. Next cycle goes to IDLE.
- Total o_busy high time: WIDTH+1 cycles (T .. T+WIDTH).
- Divide by zero (divisor==0, either mode):
  - Skip RUN and go IDLE -> DONE directly; o_busy is high for cycle T only.
  - o_quotient = all ones; o_remainder = i_dividend unmodified.
- Signed overflow (most negative value / -1): o_quotient = most negative value, o_remainder = 0. This falls out of the magnitude path and needs no special case.
- i_cancel in RUN or DONE: go to IDLE next cycle, o_done=0, o_busy drops in the same cycle (combinational). Outputs keep their previous values.
- i_cancel together with i_start in IDLE: the start is not accepted.
- Reset mid-RUN: immediate return to the reset state; no o_done is produced.
- Back-to-back DIVs: the second is accepted in the IDLE cycle after DONE, at cycle T+WIDTH+2.

Decomposition:
- Shared package:
  - div_state_t enum (IDLE, RUN, DONE)
  - DIV_WIDTH=32
  - DIV_BY_ZERO_Q constant (all ones)
- Sub-module: abs_negate, a combinational conditional two's-complement unit. It is instantiated for operand magnitude and for result sign correction.
- The iteration datapath stays inline.

Test Plan:
- DIVU 100 / 7, i_start held high from T:
  - o_busy high T..T+32; o_done at T+33.
  - quotient 14, remainder 2.
- DIV -7 / 2: quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / -2: quotient -3, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0, no hang. DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- DIVU 0x1234 / 0:
  - o_busy high one cycle only; o_done next cycle.
  - quotient 0xFFFFFFFF, remainder 0x1234.
- i_cancel at T+10:
  - o_busy drops in that cycle; state IDLE at T+11; no o_done.
  - New DIVU 9 / 3 at T+12 gives quotient 3, remainder 0 with o_done at T+45.
- Reset asserted asynchronously at T+5 mid-RUN:
  - o_busy=0 and outputs 0 immediately.
  - After release, DIVU 50 / 5 completes with quotient 10, remainder 0.

Source files
------------

// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package iterative_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/iterative_divider_if.sv
// Operand/result bundle between the EXE stage and the iterative divider.
interface iterative_divider_if #(
    parameter int WIDTH = 32
);

    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             i_cancel;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor, i_cancel,
        input  o_busy, o_done, o_quotient, o_remainder
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor, i_cancel,
        output o_busy, o_done, o_quotient, o_remainder
    );

endinterface

// File: rtl/iterative_divider_abs_negate.sv
// Conditional two's-complement negation: used both for operand magnitudes and result sign fix-up.
module abs_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, stalls the pipeline via o_busy.
module iterative_divider
    import iterative_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    iterative_divider_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] dvd_quo;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg, r_neg;

    logic             accept;
    logic             div_zero;
    logic             dvd_sign, dvsr_sign;
    logic [WIDTH-1:0] dvd_mag, dvsr_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign div_zero  = (bus.i_divisor == '0);
    assign dvd_sign  = bus.i_signed & bus.i_dividend[WIDTH-1];
    assign dvsr_sign = bus.i_signed & bus.i_divisor[WIDTH-1];

    abs_negate #(.WIDTH(WIDTH)) u_dvd_mag  (.a(bus.i_dividend), .neg(dvd_sign),  .y(dvd_mag));
    abs_negate #(.WIDTH(WIDTH)) u_dvsr_mag (.a(bus.i_divisor),  .neg(dvsr_sign), .y(dvsr_mag));

    // The dividend register doubles as the quotient: its MSB shifts into the remainder
    // while the new quotient bit enters at the LSB. rem < dvsr keeps the WIDTH+1 trial in range.
    assign shifted  = {part_rem, dvd_quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr};
    assign rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {dvd_quo[WIDTH-2:0], ~trial[WIDTH]};

    abs_negate #(.WIDTH(WIDTH)) u_quo_fix (.a(quo_step), .neg(q_neg), .y(quo_fix));
    abs_negate #(.WIDTH(WIDTH)) u_rem_fix (.a(rem_step), .neg(r_neg), .y(rem_fix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // o_busy must rise in the very cycle the instruction is seen, so the IDLE term is combinational.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        bus.o_busy = 1'b0;
        bus.o_done = 1'b0;
        unique case (state)
            IDLE: begin
                accept     = bus.i_start & ~bus.i_cancel & ~reset;
                bus.o_busy = accept;
                if (accept) begin
                    state_nxt = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                bus.o_busy = ~bus.i_cancel;
                if (bus.i_cancel) begin
                    state_nxt = IDLE;
                end else if (count == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.o_done = ~bus.i_cancel;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count           <= '0;
            part_rem        <= '0;
            dvd_quo         <= '0;
            dvsr            <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            bus.o_quotient  <= '0;
            bus.o_remainder <= '0;
        end else if (accept) begin
            count    <= CNT_W'(WIDTH - 1);
            part_rem <= '0;
            dvd_quo  <= dvd_mag;
            dvsr     <= dvsr_mag;
            q_neg    <= dvd_sign ^ dvsr_sign;
            r_neg    <= dvd_sign;
            if (div_zero) begin
                bus.o_quotient  <= {WIDTH{DIV_BY_ZERO_Q[0]}};
                bus.o_remainder <= bus.i_dividend;
            end
        end else if (state == RUN && !bus.i_cancel) begin
            count    <= count - CNT_W'(1);
            part_rem <= rem_step;
            dvd_quo  <= quo_step;
            if (count == '0) begin
                bus.o_quotient  <= quo_fix;
                bus.o_remainder <= rem_fix;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: directed corner cases plus randomized DIV/DIVU traffic.
module tb_iterative_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    exp_t sb[$];

    iterative_divider_if #(.WIDTH(W)) bus ();

    iterative_divider #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain integer division with MIPS conventions for the corner cases.
    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        exp_t   e;
        longint sa, sb_;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
            e.q = W'(sa / sb_);
            e.r = W'(sa % sb_);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.o_done) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: o_done=1 with no division outstanding at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("quotient", bus.o_quotient, e.q);
                check("remainder", bus.o_remainder, e.r);
            end
        end
    end

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
        int cyc  = 0;
        int busy = 0;
        int lat;
        bit seen = 0;
        lat = (b == '0) ? 1 : W + 1;
        @(posedge clk); #1;
        bus.i_start    = 1'b1;
        bus.i_signed   = sgn;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        sb.push_back(ref_div(a, b, sgn));
        #1 check("busy_at_start", W'(bus.o_busy), W'(1));
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (bus.o_busy) busy++;
            if (bus.o_done) begin
                seen = 1;
                bus.i_start = 1'b0;
            end else begin
                cyc++;
            end
        end
        bus.i_start = 1'b0;
        check("done_latency", W'(cyc), W'(lat));
        check("busy_cycles", W'(busy), W'(lat));
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        bus.i_start    = 1'b1;
        bus.i_signed   = 1'b0;
        bus.i_dividend = 32'd100;
        bus.i_divisor  = 32'd7;
        bus.i_cancel   = 1'b0;

        // Reset state, with a start request pending that must not raise o_busy.
        repeat (2) @(negedge clk);
        check("rst_busy", W'(bus.o_busy), W'(0));
        check("rst_done", W'(bus.o_done), W'(0));
        check("rst_quotient", bus.o_quotient, W'(0));
        check("rst_remainder", bus.o_remainder, W'(0));
        bus.i_start = 1'b0;
        reset = 1'b0;

        run_div(32'd100, 32'd7, 1'b0);
        run_div(-32'sd7, 32'd2, 1'b1);
        run_div(32'd7, -32'sd2, 1'b1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(32'h1234, 32'd0, 1'b0);
        run_div(-32'sd77, 32'd0, 1'b1);

        // Cancel mid-RUN: busy drops immediately, nothing retires.
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_signed = 1'b0;
        bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3;
        repeat (10) @(posedge clk);
        #1 check("busy_before_cancel", W'(bus.o_busy), W'(1));
        bus.i_start = 1'b0;
        bus.i_cancel = 1'b1;
        #1 check("busy_on_cancel", W'(bus.o_busy), W'(0));
        @(posedge clk); #1;
        bus.i_cancel = 1'b0;
        @(negedge clk);
        check("idle_after_cancel", W'(bus.o_busy), W'(0));
        run_div(32'd9, 32'd3, 1'b0);

        // Start together with cancel in IDLE is refused.
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_cancel = 1'b1;
        bus.i_dividend = 32'd40; bus.i_divisor = 32'd4;
        #1 check("busy_start_cancel", W'(bus.o_busy), W'(0));
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_cancel = 1'b0;
        @(negedge clk);
        check("not_accepted", W'(bus.o_busy), W'(0));

        // Asynchronous reset mid-RUN.
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_signed = 1'b0;
        bus.i_dividend = 32'd500; bus.i_divisor = 32'd7;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", W'(bus.o_busy), W'(0));
        check("arst_quotient", bus.o_quotient, W'(0));
        check("arst_remainder", bus.o_remainder, W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_div(32'd50, 32'd5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2, 3:    b = W'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            run_div(a, b, s);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
